// File: rtl/bit_serial_mult_ctrl.sv
// Sequencer for one bit-serial multiplier: streams a/b LSB-first (zero-padded to 2K bits),
// collects the 2K-bit product serially. Optional macro: BSM_CTRL_ZERO_BYPASS_EN.
module bit_serial_mult_ctrl #(
    parameter int unsigned K       = 8,
    parameter int unsigned P_DELAY = 0
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [K-1:0]   a,
    input  logic [K-1:0]   b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*K-1:0] product,
    output logic           busy,
    output logic           mult_x,
    output logic           mult_y,
    output logic           mult_first_bit,
    output logic           mult_last_bit,
    input  logic           mult_p
);

    localparam int unsigned   CW       = $clog2(2 * K);
    localparam logic [CW-1:0] LAST_IDX = CW'(2 * K - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  drv_cnt_q, drv_cnt_d;
    logic [CW-1:0]  cap_cnt_q, cap_cnt_d;
    logic [K-1:0]   a_sh_q, a_sh_d;
    logic [K-1:0]   b_sh_q, b_sh_d;
    logic [2*K-1:0] product_q, product_d;
    logic           in_ready_q, in_ready_d;
    logic           out_valid_q, out_valid_d;
    logic           busy_q, busy_d;
    logic           x_q, x_d;
    logic           y_q, y_d;
    logic           first_q, first_d;
    logic           last_q, last_d;

    logic run;
    logic accept;
    logic zero_op;
    logic cap_stb;

    assign run    = (state_q == RUN);
    assign accept = in_valid && in_ready_q;

`ifdef BSM_CTRL_ZERO_BYPASS_EN
    assign zero_op = (a == '0) || (b == '0);
`else
    assign zero_op = 1'b0;
`endif

    // Capture strobe is the drive-valid strobe delayed to line up with the multiplier's p output.
    if (P_DELAY == 0) begin : g_no_delay
        assign cap_stb = run;
    end else begin : g_delay
        logic [P_DELAY-1:0] vld_q;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                vld_q <= '0;
            end else begin
                vld_q <= (vld_q << 1) | P_DELAY'(run);
            end
        end

        assign cap_stb = vld_q[P_DELAY-1];
    end

    always_comb begin
        state_d   = state_q;
        drv_cnt_d = drv_cnt_q;
        cap_cnt_d = cap_cnt_q;
        a_sh_d    = a_sh_q;
        b_sh_d    = b_sh_q;
        product_d = product_q;
        x_d       = 1'b0;
        y_d       = 1'b0;
        first_d   = 1'b0;
        last_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    product_d = '0;
                    if (zero_op) begin
                        state_d = DONE;
                    end else begin
                        state_d   = RUN;
                        drv_cnt_d = '0;
                        cap_cnt_d = '0;
                        // Bit 0 goes out with the first_bit marker; the rest stays queued.
                        a_sh_d    = a >> 1;
                        b_sh_d    = b >> 1;
                        x_d       = a[0];
                        y_d       = b[0];
                        first_d   = 1'b1;
                    end
                end
            end
            RUN: begin
                if (drv_cnt_q == LAST_IDX) begin
                    state_d = (P_DELAY == 0) ? DONE : DRAIN;
                end else begin
                    drv_cnt_d = drv_cnt_q + 1'b1;
                    x_d       = a_sh_q[0];
                    y_d       = b_sh_q[0];
                    a_sh_d    = a_sh_q >> 1;
                    b_sh_d    = b_sh_q >> 1;
                    last_d    = (drv_cnt_q == LAST_IDX - 1'b1);
                end
            end
            DRAIN: begin
                if (cap_stb && (cap_cnt_q == LAST_IDX)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (cap_stb && (state_q == RUN || state_q == DRAIN)) begin
            product_d = {mult_p, product_q[2*K-1:1]};
            cap_cnt_d = cap_cnt_q + 1'b1;
        end

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
        busy_d      = (state_d == RUN) || (state_d == DRAIN);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            drv_cnt_q   <= '0;
            cap_cnt_q   <= '0;
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            product_q   <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            x_q         <= 1'b0;
            y_q         <= 1'b0;
            first_q     <= 1'b0;
            last_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            drv_cnt_q   <= drv_cnt_d;
            cap_cnt_q   <= cap_cnt_d;
            a_sh_q      <= a_sh_d;
            b_sh_q      <= b_sh_d;
            product_q   <= product_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            x_q         <= x_d;
            y_q         <= y_d;
            first_q     <= first_d;
            last_q      <= last_d;
        end
    end

    assign in_ready       = in_ready_q;
    assign out_valid      = out_valid_q;
    assign product        = product_q;
    assign busy           = busy_q;
    assign mult_x         = x_q;
    assign mult_y         = y_q;
    assign mult_first_bit = first_q;
    assign mult_last_bit  = last_q;

endmodule

// File: tb/tb_bit_serial_mult_ctrl.sv
// Bench for bit_serial_mult_ctrl: two K=4 instances (P_DELAY 0 and 2), each fed by a
// behavioural serial multiplier, checked every cycle against a timeline model.
module tb_bit_serial_mult_ctrl;

    localparam int K   = 4;
    localparam int PD1 = 2;

    localparam int PH_RST  = 0;
    localparam int PH_IDLE = 1;
    localparam int PH_ACT  = 2;
    localparam int PH_DONE = 3;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    logic       iv[2];
    logic       ir[2];
    logic       ov[2];
    logic       ordy[2];
    logic       bsy[2];
    logic       mx[2];
    logic       my[2];
    logic       mfb[2];
    logic       mlb[2];
    logic       mp[2];
    logic [3:0] ia[2];
    logic [3:0] ib[2];
    logic [7:0] prod[2];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bit_serial_mult_ctrl #(.K(K), .P_DELAY(0)) u_dut0 (
        .clk(clk), .reset(reset),
        .in_valid(iv[0]), .in_ready(ir[0]), .a(ia[0]), .b(ib[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]), .product(prod[0]), .busy(bsy[0]),
        .mult_x(mx[0]), .mult_y(my[0]), .mult_first_bit(mfb[0]), .mult_last_bit(mlb[0]),
        .mult_p(mp[0])
    );

    bit_serial_mult_ctrl #(.K(K), .P_DELAY(PD1)) u_dut1 (
        .clk(clk), .reset(reset),
        .in_valid(iv[1]), .in_ready(ir[1]), .a(ia[1]), .b(ib[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]), .product(prod[1]), .busy(bsy[1]),
        .mult_x(mx[1]), .mult_y(my[1]), .mult_first_bit(mfb[1]), .mult_last_bit(mlb[1]),
        .mult_p(mp[1])
    );

    // Serial multiplier stand-in: p bit i is bit i of the product of the bits seen so far.
    int unsigned cx[2];
    int unsigned cy[2];
    int unsigned cidx[2];
    int unsigned mxa[2]  = '{0, 0};
    int unsigned mya[2]  = '{0, 0};
    int unsigned midx[2] = '{0, 0};
    logic        praw[2];
    logic [3:0]  pp[2]   = '{4'd0, 4'd0};

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            cx[i]   = mfb[i] ? 32'(mx[i]) : (mxa[i] | (32'(mx[i]) << midx[i]));
            cy[i]   = mfb[i] ? 32'(my[i]) : (mya[i] | (32'(my[i]) << midx[i]));
            cidx[i] = mfb[i] ? 0 : midx[i];
            praw[i] = (((cx[i] * cy[i]) >> cidx[i]) & 32'd1) != 0;
            mp[i]   = (i == 0) ? praw[i] : pp[i][PD1-1];
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            mxa[i]  <= cx[i];
            mya[i]  <= cy[i];
            midx[i] <= (cidx[i] < 20) ? cidx[i] + 1 : 20;
            pp[i]   <= {pp[i][2:0], praw[i]};
        end
    end

    // Timeline model: m_n is the cycle number counted from the accepting edge.
    int         ph[2]  = '{PH_RST, PH_RST};
    int         m_n[2] = '{0, 0};
    logic [3:0] m_a[2] = '{4'd0, 4'd0};
    logic [3:0] m_b[2] = '{4'd0, 4'd0};
    logic [7:0] m_prod[2] = '{8'd0, 8'd0};

    function automatic int lat_of(input int i);
        return 2 * K + ((i == 0) ? 0 : PD1) + 1;
    endfunction

    always @(posedge clk or posedge reset) begin
        bit zb;
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                ph[i] <= PH_RST;
            end else begin
`ifdef BSM_CTRL_ZERO_BYPASS_EN
                zb = (ia[i] == 4'd0) || (ib[i] == 4'd0);
`else
                zb = 1'b0;
`endif
                case (ph[i])
                    PH_RST: ph[i] <= PH_IDLE;
                    PH_IDLE: begin
                        if (iv[i]) begin
                            m_a[i] <= ia[i];
                            m_b[i] <= ib[i];
                            if (zb) begin
                                ph[i]     <= PH_DONE;
                                m_prod[i] <= 8'd0;
                            end else begin
                                ph[i]     <= PH_ACT;
                                m_n[i]    <= 1;
                                m_prod[i] <= 8'(ia[i]) * 8'(ib[i]);
                            end
                        end
                    end
                    PH_ACT: begin
                        if (m_n[i] == lat_of(i) - 1) ph[i] <= PH_DONE;
                        else m_n[i] <= m_n[i] + 1;
                    end
                    default: begin
                        if (ordy[i]) ph[i] <= PH_IDLE;
                    end
                endcase
            end
        end
    end

    task automatic chk(input int i, input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s inst%0d got=%0h exp=%0h t=%0t", nm, i, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < 2; i++) begin
            bit   act;
            int   n;
            logic ex;
            logic ey;
            act = (ph[i] == PH_ACT);
            n   = m_n[i];
            ex  = (act && n >= 1 && n <= K) ? m_a[i][n-1] : 1'b0;
            ey  = (act && n >= 1 && n <= K) ? m_b[i][n-1] : 1'b0;
            chk(i, "in_ready", ir[i], ph[i] == PH_IDLE);
            chk(i, "busy", bsy[i], act);
            chk(i, "out_valid", ov[i], ph[i] == PH_DONE);
            chk(i, "mult_first_bit", mfb[i], act && n == 1);
            chk(i, "mult_last_bit", mlb[i], act && n == 2 * K);
            chk(i, "mult_x", mx[i], ex);
            chk(i, "mult_y", my[i], ey);
            if (ph[i] == PH_DONE) chk(i, "product", prod[i], m_prod[i]);
            if (ph[i] == PH_RST)  chk(i, "product_rst", prod[i], 0);
        end
    endtask

    task automatic send(input int i, input logic [3:0] a, input logic [3:0] b);
        int w = 0;
        @(negedge clk);
        while (ir[i] !== 1'b1 && w < 40) begin
            @(negedge clk);
            w++;
        end
        chk(i, "send_ready", ir[i], 1);
        iv[i] = 1'b1;
        ia[i] = a;
        ib[i] = b;
        @(posedge clk);
        #1;
        iv[i] = 1'b0;
        ia[i] = 4'($urandom);
        ib[i] = 4'($urandom);
    endtask

    task automatic lit_frame(input int i, input logic [3:0] a, input logic [3:0] b,
                             input logic [7:0] ep, input int lat, input bit frame,
                             input int hold, input bit early, input int poke);
        int nf = -1;
        int nl = -1;
        int nv = -1;
        ordy[i] = early;
        send(i, a, b);
        for (int n = 1; n <= lat; n++) begin
            @(negedge clk);
            if (poke != 0 && n == poke) begin
                iv[i] = 1'b1;
                ia[i] = 4'd1;
                ib[i] = 4'd1;
            end else begin
                iv[i] = 1'b0;
            end
            if (mfb[i] === 1'b1 && nf < 0) nf = n;
            if (mlb[i] === 1'b1 && nl < 0) nl = n;
            if (ov[i] === 1'b1 && nv < 0) nv = n;
        end
        if (frame) begin
            chk(i, "lit_first_at", nf, 1);
            chk(i, "lit_last_at", nl, 2 * K);
        end else begin
            chk(i, "lit_first_at", nf, 32'hFFFF_FFFF);
        end
        chk(i, "lit_valid_at", nv, lat);
        chk(i, "lit_product", prod[i], ep);
        chk(i, "lit_model_prod", m_prod[i], ep);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk(i, "lit_hold_valid", ov[i], 1);
            chk(i, "lit_hold_product", prod[i], ep);
            chk(i, "lit_hold_in_ready", ir[i], 0);
        end
        ordy[i] = 1'b1;
        @(negedge clk);
        chk(i, "lit_in_ready_back", ir[i], 1);
        chk(i, "lit_valid_drop", ov[i], 0);
        ordy[i] = 1'b0;
    endtask

    function automatic logic [3:0] pick();
        int r;
        r = $urandom_range(0, 7);
        if (r == 0) return 4'd0;
        if (r == 1) return 4'd15;
        return 4'($urandom_range(0, 15));
    endfunction

    initial begin
        for (int i = 0; i < 2; i++) begin
            iv[i]   = 1'b0;
            ia[i]   = 4'd0;
            ib[i]   = 4'd0;
            ordy[i] = 1'b0;
        end
        fork
            forever begin
                @(negedge clk);
                compare_all();
            end
        join_none

        #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;

        lit_frame(0, 4'd3, 4'd5, 8'h0F, 9, 1'b1, 0, 1'b1, 0);
        lit_frame(0, 4'd15, 4'd15, 8'hE1, 9, 1'b1, 5, 1'b0, 0);
        lit_frame(1, 4'd9, 4'd6, 8'h36, 11, 1'b1, 0, 1'b0, 0);

        send(0, 4'd9, 4'd5);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        chk(0, "rst_first", mfb[0], 0);
        chk(0, "rst_busy", bsy[0], 0);
        chk(0, "rst_valid", ov[0], 0);
        chk(0, "rst_in_ready", ir[0], 0);
        chk(0, "rst_x", mx[0], 0);
        chk(0, "rst_product", prod[0], 0);
        @(posedge clk);
        #2 reset = 1'b0;

        lit_frame(0, 4'd2, 4'd7, 8'h0E, 9, 1'b1, 0, 1'b0, 3);
`ifdef BSM_CTRL_ZERO_BYPASS_EN
        lit_frame(0, 4'd0, 4'd11, 8'h00, 1, 1'b0, 0, 1'b0, 0);
        lit_frame(1, 4'd0, 4'd11, 8'h00, 1, 1'b0, 0, 1'b0, 0);
`else
        lit_frame(0, 4'd0, 4'd11, 8'h00, 9, 1'b1, 0, 1'b0, 0);
        lit_frame(1, 4'd0, 4'd11, 8'h00, 11, 1'b1, 0, 1'b0, 0);
`endif

        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                iv[i]   = ($urandom_range(0, 3) == 0);
                ia[i]   = pick();
                ib[i]   = pick();
                ordy[i] = ($urandom_range(0, 2) != 0);
            end
            if (c == 1500) #3 reset = 1'b1;
            if (c == 1503) #3 reset = 1'b0;
        end

        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            iv[i]   = 1'b0;
            ordy[i] = 1'b1;
        end
        repeat (30) @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bit_serial_mult_ctrl.md
# bit_serial_mult_ctrl

Sequencer and framing controller for one `bit_serial_multiplier` instance. It accepts a pair of K-bit unsigned operands over a valid/ready handshake and streams them LSB-first into the multiplier, padded with K zero bits. It generates the `first_bit`/`last_bit` frame markers, captures the 2K-bit product serially from `p`, and presents it in parallel on a valid/ready output port. It sits between parallel-word logic and the serial multiplier datapath.

## Interface
- `K`, default 8: operand width; must match the multiplier's `K`; K ≥ 3.
- `P_DELAY`, default 0: cycles from driving bit i on `mult_x`/`mult_y` to product bit i on `mult_p`; range 0..3.
- `clk` input 1: single clock, all logic on rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `in_valid` input 1: operand pair valid.
- `in_ready` output 1: controller can accept operands.
- `a` input K: multiplicand, unsigned.
- `b` input K: multiplier, unsigned.
- `out_valid` output 1: `product` valid.
- `out_ready` input 1: consumer accepts product.
- `product` output 2K: a×b, unsigned.
- `busy` output 1: frame in progress (RUN or DRAIN).
- `mult_x` output 1: serial bit to multiplier `x`.
- `mult_y` output 1: serial bit to multiplier `y`.
- `mult_first_bit` output 1: to multiplier `first_bit`.
- `mult_last_bit` output 1: to multiplier `last_bit`.
- `mult_p` input 1: from multiplier `p`.

## Operation
- FSM states:
  - IDLE: `in_ready`=1.
  - RUN: 2K drive cycles.
  - DRAIN: P_DELAY capture cycles; skipped when P_DELAY=0.
  - DONE: `out_valid`=1.
- IDLE→RUN on `in_valid & in_ready`. `a`/`b` are latched into shift registers, the drive counter is cleared, and the product register is cleared.
- RUN, drive index d=0..2K-1:
  - `mult_x`=a[d] and `mult_y`=b[d] for d<K; both 0 for d≥K.
  - `mult_first_bit`=1 only at d=0.
  - `mult_last_bit`=1 only at d=2K-1.
  - RUN→DRAIN (or →DONE when P_DELAY=0) after d=2K-1.
- Capture: a P_DELAY-deep delay line of the drive-valid strobe gates sampling of `mult_p`. Capture index c=0..2K-1 shifts `mult_p` into product bit c; bit 0 is captured first.
- DRAIN→DONE once c=2K-1 has been captured.
- DONE: `product` is held stable. DONE→IDLE on `out_ready`.
- No overlap between frames: `in_ready`=0 outside IDLE, so a new frame starts no earlier than the cycle after the output handshake.
- Outside RUN, all `mult_*` outputs are 0.
- Arithmetic: the product is exact in 2K bits, with no overflow possible. The controller forwards `mult_p` verbatim and never corrects it.

## Timing
- All outputs are registered. Reset values:
  - `in_ready`=0 while `reset` is asserted, then 1 in the first IDLE cycle after release.
  - `out_valid`=0, `product`=0, `busy`=0.
  - `mult_x`, `mult_y`, `mult_first_bit`, `mult_last_bit`=0.
- Input handshake accepted at edge T (`in_valid & in_ready`).
  - `mult_first_bit` is high in cycle T+1.
  - `mult_last_bit` is high in cycle T+2K.
- `out_valid` rises in cycle T+2K+P_DELAY+1, so latency is 2K+P_DELAY+1 cycles.
- `out_valid` stays high and `product` stays stable until `out_ready` is sampled high. `in_ready` returns in the following cycle.
- `out_ready` asserted early (before DONE) has no effect.
- `in_valid` outside IDLE is ignored; the operands are not latched.
- `reset` mid-frame: the FSM returns to IDLE immediately and all outputs take their reset values. Any partial product is discarded. The multiplier's internal state is not cleared by this block; the next `mult_first_bit` reinitialises it.

## Configuration
- `BSM_CTRL_ZERO_BYPASS_EN`:
  - Defined: if a==0 or b==0 at acceptance, the FSM goes IDLE→DONE directly. `product`=0, `out_valid` is high in cycle T+1, and no `mult_*` activity occurs (`mult_first_bit` stays 0).
  - Undefined: every accepted pair runs the full serial frame. Latency is always 2K+P_DELAY+1.

## Test plan
- K=4, P_DELAY=0, a=3, b=5, `out_ready`=1 -> `mult_first_bit` at T+1, `mult_last_bit` at T+8, `out_valid` at T+9 with `product`=0x0F; `in_ready` high again at T+10.
- K=4, a=15, b=15, `out_ready` held 0 for 5 cycles after `out_valid` -> `product`=0xE1 stable throughout; `in_ready`=0 until the cycle after `out_ready`=1.
- K=4, P_DELAY=2, a=9, b=6 -> `out_valid` at T+11, `product`=0x36; a model multiplier with a 2-cycle delay is used.
- Reset asserted at T+4 of a frame -> all outputs 0 that cycle; after release, a new a=2, b=7 frame yields 0x0E with no corruption.
- `in_valid` pulsed with a=1, b=1 during RUN -> ignored; the running product is unchanged; no extra `out_valid`.
- With `BSM_CTRL_ZERO_BYPASS_EN`, a=0, b=11 -> `out_valid` at T+1, `product`=0, `mult_first_bit` never asserted. Without the macro, the same stimulus gives `out_valid` at T+9 and `product`=0.
